// File: rtl/nabp_processing_swap_control.sv
// nabp_processing_swap_control
// Steps the projection angle for one NABP swappable, waits for the mapper/shifter
// LUTs to settle, then answers the swappable's swap / next-iteration requests.
//
// Handshake: sw_swap and sw_next_itr are level requests. A request sampled high
// in the state that serves it is acknowledged with a one-cycle ack in the
// following cycle. After an ack the same request line must be seen low once
// before it can be served (or flagged as an error) again, so a request the
// swappable keeps high past its ack is never served twice.
module nabp_processing_swap_control #(
  parameter int pAngleWidth   = 10,
  parameter int pNoOfAngles   = 180,
  parameter int pAngleStep    = 1,
  parameter int pNoOfLineItrs = 4,
  parameter int pItrWidth     = 2,
  parameter int pLutLatency   = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   sw_swap,
  input  logic                   sw_next_itr,
  output logic                   sw_swap_ack,
  output logic                   sw_next_itr_ack,
  output logic [pAngleWidth-1:0] hs_angle,
  output logic [pItrWidth-1:0]   line_itr,
  output logic                   cfg_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_READY    = 3'd2,
    S_SWAP_ACK = 3'd3,
    S_RUN      = 3'd4,
    S_ITR_ACK  = 3'd5
  } state_t;

  localparam int WaitWidth = (pLutLatency > 1) ? $clog2(pLutLatency) : 1;

  localparam logic [pAngleWidth-1:0] LastAngle = pAngleWidth'((pNoOfAngles - 1) * pAngleStep);
  localparam logic [pAngleWidth-1:0] AngleStep = pAngleWidth'(pAngleStep);
  localparam logic [pItrWidth-1:0]   LastItr   = pItrWidth'(pNoOfLineItrs - 1);
  localparam logic [pItrWidth-1:0]   ItrOne    = pItrWidth'(1);
  localparam logic [WaitWidth-1:0]   LastWait  = WaitWidth'(pLutLatency - 1);
  localparam logic [WaitWidth-1:0]   WaitOne   = WaitWidth'(1);

  state_t                 state_q;
  logic [WaitWidth-1:0]   wait_q;
  logic [pAngleWidth-1:0] angle_q;
  logic [pItrWidth-1:0]   itr_q;
  logic                   cfg_valid_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;
  logic                   swap_ack_q;
  logic                   itr_ack_q;
  logic                   swap_hold_q;
  logic                   itr_hold_q;

  // A request only counts once its line has dropped since the previous ack.
  logic swap_req;
  logic itr_req;
  logic take_swap;
  logic take_itr;

  assign swap_req  = sw_swap & ~swap_hold_q;
  assign itr_req   = sw_next_itr & ~itr_hold_q;
  assign take_swap = (state_q == S_READY) & swap_req;
  assign take_itr  = (state_q == S_RUN) & itr_req;

  // Hold-off flags: set when a request is accepted, cleared once its line is seen low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      swap_hold_q <= 1'b0;
      itr_hold_q  <= 1'b0;
    end else begin
      if (take_swap)        swap_hold_q <= 1'b1;
      else if (!sw_swap)    swap_hold_q <= 1'b0;
      if (take_itr)         itr_hold_q  <= 1'b1;
      else if (!sw_next_itr) itr_hold_q <= 1'b0;
    end
  end

  // Main sequencer: angle stepping, LUT settle wait, ack generation, run status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      angle_q     <= '0;
      itr_q       <= '0;
      cfg_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      swap_ack_q  <= 1'b0;
      itr_ack_q   <= 1'b0;
    end else begin
      swap_ack_q <= 1'b0;
      itr_ack_q  <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_LOOKUP;
            wait_q      <= '0;
            angle_q     <= '0;
            itr_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            cfg_valid_q <= 1'b0;
          end
        end
        S_LOOKUP: begin
          if (wait_q == LastWait) begin
            state_q     <= S_READY;
            wait_q      <= '0;
            cfg_valid_q <= 1'b1;
          end else begin
            wait_q <= wait_q + WaitOne;
          end
        end
        S_READY: begin
          // A swap wins over a simultaneous next-iteration request.
          if (take_swap) begin
            state_q    <= S_SWAP_ACK;
            swap_ack_q <= 1'b1;
          end else if (itr_req) begin
            err_q <= 1'b1;
          end
        end
        S_SWAP_ACK: begin
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (take_itr) begin
            state_q   <= S_ITR_ACK;
            itr_ack_q <= 1'b1;
          end
          if (swap_req) begin
            err_q <= 1'b1;
          end
        end
        S_ITR_ACK: begin
          if (itr_q != LastItr) begin
            itr_q   <= itr_q + ItrOne;
            state_q <= S_READY;
          end else if (angle_q != LastAngle) begin
            itr_q       <= '0;
            angle_q     <= angle_q + AngleStep;
            cfg_valid_q <= 1'b0;
            wait_q      <= '0;
            state_q     <= S_LOOKUP;
          end else begin
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            cfg_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sw_swap_ack     = swap_ack_q;
  assign sw_next_itr_ack = itr_ack_q;
  assign hs_angle        = angle_q;
  assign line_itr        = itr_q;
  assign cfg_valid       = cfg_valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_nabp_processing_swap_control.sv
// Bench for nabp_processing_swap_control: a randomised swappable drives the
// request lines, a run-level reference model predicts every output each cycle,
// and a directed clean run pins exact timing and angle sequence.
module tb_nabp_processing_swap_control;

  localparam int AW   = 10;
  localparam int NA   = 3;
  localparam int STEP = 90;
  localparam int NI   = 2;
  localparam int IW   = 2;
  localparam int LAT  = 3;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic start       = 1'b0;
  logic sw_swap     = 1'b0;
  logic sw_next_itr = 1'b0;
  logic          sw_swap_ack;
  logic          sw_next_itr_ack;
  logic [AW-1:0] hs_angle;
  logic [IW-1:0] line_itr;
  logic          cfg_valid;
  logic          busy;
  logic          done;
  logic          err;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  nabp_processing_swap_control #(
    .pAngleWidth(AW), .pNoOfAngles(NA), .pAngleStep(STEP),
    .pNoOfLineItrs(NI), .pItrWidth(IW), .pLutLatency(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .sw_swap(sw_swap), .sw_next_itr(sw_next_itr),
    .sw_swap_ack(sw_swap_ack), .sw_next_itr_ack(sw_next_itr_ack),
    .hs_angle(hs_angle), .line_itr(line_itr), .cfg_valid(cfg_valid),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the run in terms of angle index, iteration, remaining settle cycles
  // and whether this iteration's swap has been granted.
  bit m_busy, m_err, m_done, m_sa, m_ia, m_cfg, m_swapped, m_sblk, m_iblk;
  bit p_sa, p_ia, s_req, i_req;
  int m_angle_idx, m_itr, m_lookup_left;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_err = 0; m_done = 0; m_sa = 0; m_ia = 0; m_cfg = 0;
      m_swapped = 0; m_sblk = 0; m_iblk = 0;
      m_angle_idx = 0; m_itr = 0; m_lookup_left = 0;
    end else begin
      s_req = sw_swap && !m_sblk;
      i_req = sw_next_itr && !m_iblk;
      p_sa = m_sa;
      p_ia = m_ia;
      m_sa = 0; m_ia = 0; m_done = 0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_err = 0; m_cfg = 0; m_swapped = 0;
          m_angle_idx = 0; m_itr = 0; m_lookup_left = LAT;
        end
      end else if (p_sa) begin
        m_swapped = 1;
      end else if (p_ia) begin
        m_swapped = 0;
        if (m_itr < NI - 1) begin
          m_itr++;
        end else if (m_angle_idx < NA - 1) begin
          m_angle_idx++; m_itr = 0; m_cfg = 0; m_lookup_left = LAT;
        end else begin
          m_done = 1; m_busy = 0; m_cfg = 0;
        end
      end else if (m_lookup_left > 0) begin
        m_lookup_left--;
        if (m_lookup_left == 0) m_cfg = 1;
      end else if (!m_swapped) begin
        if (s_req) m_sa = 1;
        else if (i_req) m_err = 1;
      end else begin
        if (i_req) m_ia = 1;
        if (s_req) m_err = 1;
      end
      if (m_sa) m_sblk = 1; else if (!sw_swap) m_sblk = 0;
      if (m_ia) m_iblk = 1; else if (!sw_next_itr) m_iblk = 0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("sw_swap_ack", sw_swap_ack, m_sa);
    check("sw_next_itr_ack", sw_next_itr_ack, m_ia);
    check("hs_angle", hs_angle, m_angle_idx * STEP);
    check("line_itr", line_itr, m_itr);
    check("cfg_valid", cfg_valid, m_cfg);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("err", err, m_err);
  end

  // ---------------- swappable driver ----------------
  bit chaos = 0;
  bit want_swap = 1, s_rel_on = 0, i_rel_on = 0;
  int s_rel = 0, i_rel = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      sw_swap = 0; sw_next_itr = 0; want_swap = 1; s_rel_on = 0; i_rel_on = 0;
    end else begin
      if (sw_swap_ack) begin
        want_swap = 0; s_rel_on = 1;
        s_rel = (chaos && $urandom_range(0, 3) == 0) ? 3 : 0;
      end
      if (sw_next_itr_ack) begin
        want_swap = 1; i_rel_on = 1;
        i_rel = (chaos && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      if (s_rel_on) begin
        if (s_rel == 0) begin sw_swap = 0; s_rel_on = 0; end else s_rel--;
      end else if (!sw_swap) begin
        if (want_swap && busy && (!chaos || $urandom_range(0, 2) == 0)) sw_swap = 1;
        else if (chaos && !want_swap && $urandom_range(0, 15) == 0) sw_swap = 1;
      end else if (chaos && !want_swap) begin
        sw_swap = 0;
      end
      if (i_rel_on) begin
        if (i_rel == 0) begin sw_next_itr = 0; i_rel_on = 0; end else i_rel--;
      end else if (!sw_next_itr) begin
        if (!want_swap && busy && (!chaos || $urandom_range(0, 2) == 0)) sw_next_itr = 1;
        else if (chaos && want_swap && $urandom_range(0, 15) == 0) sw_next_itr = 1;
      end else if (chaos && want_swap) begin
        sw_next_itr = 0;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int exp_angles[6] = '{0, 0, 90, 90, 180, 180};
  int exp_itrs[6]   = '{0, 1, 0, 1, 0, 1};
  int ack_angles[$];
  int itr_at_ack[$];
  int first_ack, done_at, done_cnt, waited;
  bit seen;

  initial begin
    #1 reset_n = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cfg_valid", cfg_valid, 0);
    check("rst_hs_angle", hs_angle, 0);
    check("rst_line_itr", line_itr, 0);
    check("rst_acks", {sw_swap_ack, sw_next_itr_ack}, 0);
    @(posedge clk); #2 reset_n = 1;

    // Directed clean run: swap raised the cycle after start, every request
    // dropped right after its ack.
    chaos = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    first_ack = -1; done_at = -1; done_cnt = 0;
    for (int k = 1; k <= 200 && done_at < 0; k++) begin
      if (k > 1) @(negedge clk);
      if (sw_swap_ack) begin
        if (first_ack < 0) begin
          first_ack = k;
          check("early_swap_cfg_valid", cfg_valid, 1);
        end
        ack_angles.push_back(int'(hs_angle));
      end
      if (sw_next_itr_ack) itr_at_ack.push_back(int'(line_itr));
      if (done) begin
        done_at = k; done_cnt++;
        check("busy_falls_with_done", busy, 0);
        check("err_clean_run", err, 0);
      end
    end
    check("first_swap_ack_cycle", first_ack, 5);
    check("done_cycle", done_at, 34);
    check("swap_ack_count", ack_angles.size(), 6);
    check("itr_ack_count", itr_at_ack.size(), 6);
    for (int i = 0; i < 6 && i < ack_angles.size(); i++) check("ack_angle", ack_angles[i], exp_angles[i]);
    for (int i = 0; i < 6 && i < itr_at_ack.size(); i++) check("itr_at_ack", itr_at_ack[i], exp_itrs[i]);
    repeat (5) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("single_done_pulse", done_cnt, 1);

    // Reset in the middle of a run.
    chaos = 1;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (sw_swap_ack) seen = 1;
    end
    check("reached_swap_before_reset", seen, 1);
    @(posedge clk); #2 reset_n = 0;
    @(negedge clk);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_cfg", cfg_valid, 0);
    @(posedge clk); #2 reset_n = 1;
    done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("no_done_after_reset", done_cnt, 0);

    // Randomised runs, with stray requests, held requests and start while busy.
    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
      seen = 0;
      waited = 0;
      while (!seen && waited < 800) begin
        @(negedge clk);
        waited++;
        if (done) seen = 1;
        start = !seen && ($urandom_range(0, 40) == 0);
      end
      start = 0;
      check("random_run_done", seen, 1);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
